// File: rtl/leaf_rd_burst_gen.sv
// Leaf read-burst generator: splits a transfer into AXI AR bursts, throttled by
// free leaf-buffer credit, and reports done once every burst has returned rlast.
module leaf_rd_burst_gen #(
   parameter int C_M_AXI_ADDR_WIDTH = 64,
   parameter int C_M_AXI_DATA_WIDTH = 512,
   parameter int C_XFER_SIZE_WIDTH  = 32,
   parameter int C_BURST_BYTES      = 1024,
   parameter int C_BUF_BEATS        = 64
) (
   input  logic                          ap_clk,
   input  logic                          areset,
   input  logic                          start,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
   input  logic [C_XFER_SIZE_WIDTH-1:0]  xfer_bytes,
   output logic                          m_axi_arvalid,
   input  logic                          m_axi_arready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]                    m_axi_arlen,
   input  logic                          r_last_hs,
   input  logic                          buf_release,
   output logic                          busy,
   output logic                          done
);

   localparam int AW          = C_M_AXI_ADDR_WIDTH;
   localparam int XW          = C_XFER_SIZE_WIDTH;
   localparam int BEAT_BYTES  = C_M_AXI_DATA_WIDTH / 8;
   localparam int BEAT_SHIFT  = $clog2(BEAT_BYTES);
   localparam int BURST_BEATS = C_BURST_BYTES / BEAT_BYTES;
   localparam int CW          = $clog2(C_BUF_BEATS + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [AW-1:0]   addr;
   logic [XW-1:0]   remaining;
   logic [CW-1:0]   credit;
   logic [CW-1:0]   credit_nxt;
   logic [CW:0]     credit_sum;
   logic [7:0]      out_cnt;
   logic [CW-1:0]   beats;
   logic [XW-1:0]   burst_bytes;
   logic            can_issue;
   logic            ar_hs;
   logic            last_burst;
   logic            rlast_ok;

   // Size of the pending burst: a full burst, or whatever is left if shorter.
   always_comb begin
      beats = CW'(BURST_BEATS);
      if (remaining < XW'(C_BURST_BYTES)) begin
         beats = CW'(remaining >> BEAT_SHIFT);
      end
      burst_bytes = XW'(beats) << BEAT_SHIFT;
      last_burst  = (remaining == burst_bytes);
      can_issue   = (state == REQ) && (credit >= beats);
      ar_hs       = can_issue && m_axi_arready;
      rlast_ok    = r_last_hs && (out_cnt != 8'd0);
   end

   // Handshake and release can coincide; saturate so a release at full credit is dropped.
   always_comb begin
      credit_sum = {1'b0, credit} + (buf_release ? (CW+1)'(1) : (CW+1)'(0));
      if (ar_hs) begin
         credit_sum = credit_sum - {1'b0, beats};
      end
      credit_nxt = credit_sum[CW-1:0];
      if (credit_sum > (CW+1)'(C_BUF_BEATS)) begin
         credit_nxt = CW'(C_BUF_BEATS);
      end
   end

   always_ff @(posedge ap_clk) begin
      if (areset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A zero-byte transfer skips REQ so done follows start by exactly one cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (xfer_bytes == '0) ? WAIT : REQ;
            end
         end
         REQ: begin
            if (ar_hs && last_burst) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (out_cnt == 8'd0) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (areset) begin
         addr      <= '0;
         remaining <= '0;
         credit    <= CW'(C_BUF_BEATS);
         out_cnt   <= 8'd0;
      end else begin
         if (state == IDLE && start) begin
            addr      <= base_addr;
            remaining <= xfer_bytes;
            credit    <= CW'(C_BUF_BEATS);
         end else begin
            credit <= credit_nxt;
            if (ar_hs) begin
               addr      <= addr + AW'(burst_bytes);
               remaining <= remaining - burst_bytes;
            end
         end
         if (ar_hs && !rlast_ok) begin
            out_cnt <= out_cnt + 8'd1;
         end else if (!ar_hs && rlast_ok) begin
            out_cnt <= out_cnt - 8'd1;
         end
      end
   end

   // Address/length only come from registered state, so they hold while arready is low.
   always_comb begin
      m_axi_arvalid = !areset && can_issue;
      m_axi_araddr  = m_axi_arvalid ? addr : '0;
      m_axi_arlen   = m_axi_arvalid ? 8'(beats - CW'(1)) : 8'd0;
      busy          = !areset && (state != IDLE);
      done          = !areset && (state == WAIT) && (out_cnt == 8'd0);
   end

endmodule

// File: tb/tb_leaf_rd_burst_gen.sv
// Directed bench for leaf_rd_burst_gen: a vector table of whole transfers plus
// hand-written sequences for credit stalls, arready stalls and mid-transfer reset.
module tb_leaf_rd_burst_gen;

   logic        ap_clk = 1'b0;
   logic        areset;
   logic        start;
   logic [63:0] base_addr;
   logic [31:0] xfer_bytes;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [63:0] m_axi_araddr;
   logic [7:0]  m_axi_arlen;
   logic        r_last_hs;
   logic        buf_release;
   logic        busy;
   logic        done;

   int tests    = 0;
   int failures = 0;
   int ar_iters[$];
   int done_iter;
   int busy_bad;
   int last_len;
   int credit_log[64];

   typedef struct {
      logic [63:0] base;
      logic [31:0] bytes;
      int          exp_ars;
      int          exp_last_len;
      int          restart_at;
   } vec_t;

   vec_t vecs[7];

   leaf_rd_burst_gen dut (
      .ap_clk        (ap_clk),
      .areset        (areset),
      .start         (start),
      .base_addr     (base_addr),
      .xfer_bytes    (xfer_bytes),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arlen   (m_axi_arlen),
      .r_last_hs     (r_last_hs),
      .buf_release   (buf_release),
      .busy          (busy),
      .done          (done)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One transfer: iteration i drives inputs just after a rising edge and samples at the
   // following falling edge; a reference model tracks the expected next burst.
   task automatic applyStimulus(input logic [63:0] base, input logic [31:0] bytes,
                                input int stall_n, input int rel_from, input int rel_n,
                                input int reset_at, input int restart_at);
      logic [63:0] m_addr;
      logic [31:0] m_rem;
      int          beats;
      int          due[$];
      int          limit;
      bit          fin;
      ar_iters.delete();
      done_iter = -1;
      busy_bad  = 0;
      last_len  = -1;
      m_addr    = base;
      m_rem     = bytes;
      @(posedge ap_clk); #1;
      start = 1'b1; base_addr = base; xfer_bytes = bytes;
      @(negedge ap_clk);
      checkOutput("busy_before_start", 64'(busy), 64'd0);
      limit = (reset_at >= 0) ? reset_at + 20 : 400;
      fin = 1'b0;
      for (int i = 0; i < limit && !fin; i++) begin
         @(posedge ap_clk); #1;
         start = (i == restart_at);
         if (i == restart_at) begin
            base_addr  = 64'hDEAD_0000;
            xfer_bytes = 32'd64;
         end
         m_axi_arready = (i >= stall_n);
         buf_release   = (rel_n > 0) && (i >= rel_from) && (i < rel_from + rel_n);
         r_last_hs     = 1'b0;
         if (due.size() > 0 && due[0] == i) begin
            r_last_hs = 1'b1;
            void'(due.pop_front());
         end
         if (reset_at >= 0) areset = (i >= reset_at) && (i < reset_at + 2);
         @(negedge ap_clk);
         if (i < 64) credit_log[i] = int'(dut.credit);
         if (areset) begin
            checkOutput("reset_ctrl", {53'd0, m_axi_arvalid, m_axi_arlen, busy, done}, 64'd0);
            checkOutput("reset_araddr", m_axi_araddr, 64'd0);
         end else begin
            if (m_axi_arvalid) begin
               if (m_rem == 32'd0) begin
                  checkOutput("ar_extra", 64'd1, 64'd0);
               end else begin
                  beats = (m_rem >= 32'd1024) ? 16 : int'(m_rem / 64);
                  checkOutput("araddr", m_axi_araddr, m_addr);
                  checkOutput("arlen", 64'(m_axi_arlen), 64'(beats - 1));
                  if (m_axi_arready) begin
                     ar_iters.push_back(i);
                     last_len = int'(m_axi_arlen);
                     m_addr  += 64'(beats * 64);
                     m_rem   -= 32'(beats * 64);
                     due.push_back(i + 10);
                  end
               end
            end
            if (reset_at < 0 && done_iter < 0 && !busy) busy_bad++;
            if (done && done_iter < 0) begin
               done_iter = i;
            end else if (done_iter >= 0 && i == done_iter + 1) begin
               checkOutput("busy_after_done", 64'(busy), 64'd0);
               checkOutput("done_one_cycle", 64'(done), 64'd0);
               fin = 1'b1;
            end
         end
      end
      start = 1'b0; buf_release = 1'b0; r_last_hs = 1'b0; m_axi_arready = 1'b1;
      if (reset_at < 0 && done_iter < 0) checkOutput("done_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      vecs[0] = '{64'h1000,        32'd4096, 4, 15, -1};
      vecs[1] = '{64'h4000,        32'd1088, 2,  0, -1};
      vecs[2] = '{64'h0,           32'd0,    0,  0, -1};
      vecs[3] = '{64'h10000,       32'd64,   1,  0, -1};
      vecs[4] = '{64'h2400,        32'd2048, 2, 15,  1};
      vecs[5] = '{64'h1_0000_0400, 32'd3072, 3, 15, -1};
      vecs[6] = '{64'h800,         32'd1984, 2, 14, -1};

      areset = 1'b1; start = 1'b0; base_addr = '0; xfer_bytes = '0;
      m_axi_arready = 1'b1; r_last_hs = 1'b0; buf_release = 1'b0;
      repeat (3) @(posedge ap_clk);
      @(negedge ap_clk);
      checkOutput("por_ctrl", {53'd0, m_axi_arvalid, m_axi_arlen, busy, done}, 64'd0);
      checkOutput("por_araddr", m_axi_araddr, 64'd0);
      checkOutput("por_credit", 64'(dut.credit), 64'd64);
      @(posedge ap_clk); #1;
      areset = 1'b0;
      repeat (2) @(negedge ap_clk);
      checkOutput("idle_after_reset", {62'd0, m_axi_arvalid, busy}, 64'd0);

      for (int v = 0; v < 7; v++) begin
         applyStimulus(vecs[v].base, vecs[v].bytes, 0, -1, 0, -1, vecs[v].restart_at);
         checkOutput("ar_count", 64'(ar_iters.size()), 64'(vecs[v].exp_ars));
         checkOutput("busy_held", 64'(busy_bad), 64'd0);
         if (vecs[v].exp_ars == 0) begin
            checkOutput("zero_done_iter", 64'(done_iter), 64'd0);
         end else begin
            checkOutput("first_ar_iter", 64'(ar_iters[0]), 64'd0);
            checkOutput("back_to_back", 64'(ar_iters[ar_iters.size()-1]), 64'(vecs[v].exp_ars - 1));
            checkOutput("last_arlen", 64'(last_len), 64'(vecs[v].exp_last_len));
            checkOutput("done_after_rlast", 64'(done_iter), 64'(vecs[v].exp_ars - 1 + 11));
         end
      end

      // Credit exhaustion: four bursts drain 64 beats, the fifth waits for 16 releases.
      applyStimulus(64'h2000, 32'd5120, 0, 30, 16, -1, -1);
      checkOutput("credit_drained", 64'(credit_log[20]), 64'd0);
      checkOutput("credit_ar_count", 64'(ar_iters.size()), 64'd5);
      checkOutput("fourth_ar_iter", 64'(ar_iters[3]), 64'd3);
      checkOutput("fifth_ar_iter", 64'(ar_iters[4]), 64'd46);

      // arready stall with releases at full credit, then handshake plus release together.
      applyStimulus(64'h8000, 32'd4096, 5, 0, 6, -1, -1);
      checkOutput("stall_first_ar", 64'(ar_iters[0]), 64'd5);
      checkOutput("credit_saturated", 64'(credit_log[5]), 64'd64);
      checkOutput("credit_hs_release", 64'(credit_log[6]), 64'd49);
      checkOutput("stall_ar_count", 64'(ar_iters.size()), 64'd4);

      // Reset after the second AR abandons the transfer; the next one completes.
      applyStimulus(64'h1000, 32'd4096, 0, -1, 0, 2, -1);
      checkOutput("abort_ar_count", 64'(ar_iters.size()), 64'd2);
      checkOutput("abort_no_done", 64'(done_iter), 64'hFFFF_FFFF_FFFF_FFFF);
      applyStimulus(64'h3000, 32'd1024, 0, -1, 0, -1, -1);
      checkOutput("post_reset_ar_count", 64'(ar_iters.size()), 64'd1);
      checkOutput("post_reset_done", 64'(done_iter), 64'd11);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
